register_bank_16x64: RTL and testbench



---
 rtl/register_bank_pkg.sv | 20 ++
 rtl/register_bank_16x64_lane_regfile.sv | 69 ++++++
 rtl/register_bank_16x64.sv | 151 +++++++++++++++
 tb/tb_register_bank_16x64.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : register_bank_pkg
// Purpose : Shared sizing constants and data types for the SIMD vector
//           register file (16 lanes x 64 registers x 32 bits).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package register_bank_pkg;

    localparam int NUM_LANES = 16;
    localparam int NUM_REGS  = 64;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0] lane_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : register_bank_pkg
`default_nettype wire

// File: rtl/register_bank_16x64_lane_regfile.sv
`default_nettype none
// ============================================================================
// Module  : lane_regfile
// Purpose : One lane of the vector register file: NUM_REGS x DATA_W storage
//           with one synchronous write port and two independent,
//           combinational, individually-enabled read ports.
// Ports   : clk, rst_n          clock / async active-low clear of all regs
//           we, waddr, wdata    write port (stored on rising clk)
//           re_0, raddr_0       read port 0 enable / address
//           rdata_0             read port 0 data (0 when disabled)
//           re_1, raddr_1       read port 1 enable / address
//           rdata_1             read port 1 data (0 when disabled)
// Rev     : 1.0  initial release
// ============================================================================
module lane_regfile
    import register_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_0,
    input  logic [ADDR_W-1:0] raddr_0,
    output logic [DATA_W-1:0] rdata_0,
    input  logic              re_1,
    input  logic [ADDR_W-1:0] raddr_1,
    output logic [DATA_W-1:0] rdata_1
);

    lane_data_t mem_q [NUM_REGS];
    lane_data_t mem_d [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Reads come straight from stored state: no bypass from the write port,
    // so a same-address write becomes visible only after the edge.
    always_comb begin
        rdata_0 = '0;
        rdata_1 = '0;
        if (re_0) begin
            rdata_0 = mem_q[raddr_0];
        end
        if (re_1) begin
            rdata_1 = mem_q[raddr_1];
        end
    end

endmodule : lane_regfile
`default_nettype wire

// File: rtl/register_bank_16x64.sv
`default_nettype none
// ============================================================================
// Module  : register_bank_16x64
// Purpose : SIMD vector register file, 16 lanes x 64 regs x 32 bits.
//           Shared write address with per-lane write enable; two shared read
//           addresses with per-lane read enables. Reads are combinational,
//           writes land on the rising clock edge.
// Ports   : clk, rst_n                 clock / async active-low clear
//           write_en[15:0], waddr      per-lane write enable, shared address
//           wdata_0 .. wdata_15        per-lane write data
//           read_en_0[15:0], raddr_0   port 0 per-lane enable, shared address
//           rdata_0_0 .. rdata_0_15    port 0 per-lane read data
//           read_en_1[15:0], raddr_1   port 1 per-lane enable, shared address
//           rdata_1_0 .. rdata_1_15    port 1 per-lane read data
// Rev     : 1.0  initial release
// ============================================================================
module register_bank_16x64
    import register_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] write_en,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata_0,
    input  logic [DATA_W-1:0]    wdata_1,
    input  logic [DATA_W-1:0]    wdata_2,
    input  logic [DATA_W-1:0]    wdata_3,
    input  logic [DATA_W-1:0]    wdata_4,
    input  logic [DATA_W-1:0]    wdata_5,
    input  logic [DATA_W-1:0]    wdata_6,
    input  logic [DATA_W-1:0]    wdata_7,
    input  logic [DATA_W-1:0]    wdata_8,
    input  logic [DATA_W-1:0]    wdata_9,
    input  logic [DATA_W-1:0]    wdata_10,
    input  logic [DATA_W-1:0]    wdata_11,
    input  logic [DATA_W-1:0]    wdata_12,
    input  logic [DATA_W-1:0]    wdata_13,
    input  logic [DATA_W-1:0]    wdata_14,
    input  logic [DATA_W-1:0]    wdata_15,
    input  logic [NUM_LANES-1:0] read_en_0,
    input  logic [ADDR_W-1:0]    raddr_0,
    input  logic [NUM_LANES-1:0] read_en_1,
    input  logic [ADDR_W-1:0]    raddr_1,
    output logic [DATA_W-1:0]    rdata_0_0,
    output logic [DATA_W-1:0]    rdata_0_1,
    output logic [DATA_W-1:0]    rdata_0_2,
    output logic [DATA_W-1:0]    rdata_0_3,
    output logic [DATA_W-1:0]    rdata_0_4,
    output logic [DATA_W-1:0]    rdata_0_5,
    output logic [DATA_W-1:0]    rdata_0_6,
    output logic [DATA_W-1:0]    rdata_0_7,
    output logic [DATA_W-1:0]    rdata_0_8,
    output logic [DATA_W-1:0]    rdata_0_9,
    output logic [DATA_W-1:0]    rdata_0_10,
    output logic [DATA_W-1:0]    rdata_0_11,
    output logic [DATA_W-1:0]    rdata_0_12,
    output logic [DATA_W-1:0]    rdata_0_13,
    output logic [DATA_W-1:0]    rdata_0_14,
    output logic [DATA_W-1:0]    rdata_0_15,
    output logic [DATA_W-1:0]    rdata_1_0,
    output logic [DATA_W-1:0]    rdata_1_1,
    output logic [DATA_W-1:0]    rdata_1_2,
    output logic [DATA_W-1:0]    rdata_1_3,
    output logic [DATA_W-1:0]    rdata_1_4,
    output logic [DATA_W-1:0]    rdata_1_5,
    output logic [DATA_W-1:0]    rdata_1_6,
    output logic [DATA_W-1:0]    rdata_1_7,
    output logic [DATA_W-1:0]    rdata_1_8,
    output logic [DATA_W-1:0]    rdata_1_9,
    output logic [DATA_W-1:0]    rdata_1_10,
    output logic [DATA_W-1:0]    rdata_1_11,
    output logic [DATA_W-1:0]    rdata_1_12,
    output logic [DATA_W-1:0]    rdata_1_13,
    output logic [DATA_W-1:0]    rdata_1_14,
    output logic [DATA_W-1:0]    rdata_1_15
);

    // Flattened per-lane ports gathered into lane-indexed arrays.
    lane_data_t w_wdata   [NUM_LANES];
    lane_data_t w_rdata_0 [NUM_LANES];
    lane_data_t w_rdata_1 [NUM_LANES];

    assign w_wdata[0]  = wdata_0;
    assign w_wdata[1]  = wdata_1;
    assign w_wdata[2]  = wdata_2;
    assign w_wdata[3]  = wdata_3;
    assign w_wdata[4]  = wdata_4;
    assign w_wdata[5]  = wdata_5;
    assign w_wdata[6]  = wdata_6;
    assign w_wdata[7]  = wdata_7;
    assign w_wdata[8]  = wdata_8;
    assign w_wdata[9]  = wdata_9;
    assign w_wdata[10] = wdata_10;
    assign w_wdata[11] = wdata_11;
    assign w_wdata[12] = wdata_12;
    assign w_wdata[13] = wdata_13;
    assign w_wdata[14] = wdata_14;
    assign w_wdata[15] = wdata_15;

    assign rdata_0_0  = w_rdata_0[0];
    assign rdata_0_1  = w_rdata_0[1];
    assign rdata_0_2  = w_rdata_0[2];
    assign rdata_0_3  = w_rdata_0[3];
    assign rdata_0_4  = w_rdata_0[4];
    assign rdata_0_5  = w_rdata_0[5];
    assign rdata_0_6  = w_rdata_0[6];
    assign rdata_0_7  = w_rdata_0[7];
    assign rdata_0_8  = w_rdata_0[8];
    assign rdata_0_9  = w_rdata_0[9];
    assign rdata_0_10 = w_rdata_0[10];
    assign rdata_0_11 = w_rdata_0[11];
    assign rdata_0_12 = w_rdata_0[12];
    assign rdata_0_13 = w_rdata_0[13];
    assign rdata_0_14 = w_rdata_0[14];
    assign rdata_0_15 = w_rdata_0[15];

    assign rdata_1_0  = w_rdata_1[0];
    assign rdata_1_1  = w_rdata_1[1];
    assign rdata_1_2  = w_rdata_1[2];
    assign rdata_1_3  = w_rdata_1[3];
    assign rdata_1_4  = w_rdata_1[4];
    assign rdata_1_5  = w_rdata_1[5];
    assign rdata_1_6  = w_rdata_1[6];
    assign rdata_1_7  = w_rdata_1[7];
    assign rdata_1_8  = w_rdata_1[8];
    assign rdata_1_9  = w_rdata_1[9];
    assign rdata_1_10 = w_rdata_1[10];
    assign rdata_1_11 = w_rdata_1[11];
    assign rdata_1_12 = w_rdata_1[12];
    assign rdata_1_13 = w_rdata_1[13];
    assign rdata_1_14 = w_rdata_1[14];
    assign rdata_1_15 = w_rdata_1[15];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_regfile u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (write_en[k]),
            .waddr   (waddr),
            .wdata   (w_wdata[k]),
            .re_0    (read_en_0[k]),
            .raddr_0 (raddr_0),
            .rdata_0 (w_rdata_0[k]),
            .re_1    (read_en_1[k]),
            .raddr_1 (raddr_1),
            .rdata_1 (w_rdata_1[k])
        );
    end : g_lane

endmodule : register_bank_16x64
`default_nettype wire

// File: tb/tb_register_bank_16x64.sv
`default_nettype none
// ============================================================================
// Module  : tb_register_bank_16x64
// Purpose : Self-checking bench for register_bank_16x64. A lane x register
//           array holds the expected contents; reads are predicted from it.
// Rev     : 1.0  initial release
// ============================================================================
module tb_register_bank_16x64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] write_en;
    logic [5:0]  waddr;
    logic [31:0] wd  [16];
    logic [15:0] read_en_0;
    logic [5:0]  raddr_0;
    logic [15:0] read_en_1;
    logic [5:0]  raddr_1;
    logic [31:0] rd0 [16];
    logic [31:0] rd1 [16];

    logic [31:0] model [16][64];
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    register_bank_16x64 dut (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .waddr(waddr),
        .wdata_0(wd[0]),   .wdata_1(wd[1]),   .wdata_2(wd[2]),   .wdata_3(wd[3]),
        .wdata_4(wd[4]),   .wdata_5(wd[5]),   .wdata_6(wd[6]),   .wdata_7(wd[7]),
        .wdata_8(wd[8]),   .wdata_9(wd[9]),   .wdata_10(wd[10]), .wdata_11(wd[11]),
        .wdata_12(wd[12]), .wdata_13(wd[13]), .wdata_14(wd[14]), .wdata_15(wd[15]),
        .read_en_0(read_en_0), .raddr_0(raddr_0),
        .read_en_1(read_en_1), .raddr_1(raddr_1),
        .rdata_0_0(rd0[0]),   .rdata_0_1(rd0[1]),   .rdata_0_2(rd0[2]),   .rdata_0_3(rd0[3]),
        .rdata_0_4(rd0[4]),   .rdata_0_5(rd0[5]),   .rdata_0_6(rd0[6]),   .rdata_0_7(rd0[7]),
        .rdata_0_8(rd0[8]),   .rdata_0_9(rd0[9]),   .rdata_0_10(rd0[10]), .rdata_0_11(rd0[11]),
        .rdata_0_12(rd0[12]), .rdata_0_13(rd0[13]), .rdata_0_14(rd0[14]), .rdata_0_15(rd0[15]),
        .rdata_1_0(rd1[0]),   .rdata_1_1(rd1[1]),   .rdata_1_2(rd1[2]),   .rdata_1_3(rd1[3]),
        .rdata_1_4(rd1[4]),   .rdata_1_5(rd1[5]),   .rdata_1_6(rd1[6]),   .rdata_1_7(rd1[7]),
        .rdata_1_8(rd1[8]),   .rdata_1_9(rd1[9]),   .rdata_1_10(rd1[10]), .rdata_1_11(rd1[11]),
        .rdata_1_12(rd1[12]), .rdata_1_13(rd1[13]), .rdata_1_14(rd1[14]), .rdata_1_15(rd1[15])
    );

    task automatic chk(input string tag, input int lane, input int addr,
                       input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s lane%0d addr%0d: observed %h expected %h", tag, lane, addr, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 16; k++)
            for (int a = 0; a < 64; a++)
                model[k][a] = 32'h0;
    endtask

    task automatic randomize_wd();
        for (int k = 0; k < 16; k++) wd[k] = $urandom;
    endtask

    // Drive both read ports, let them settle, compare every lane to the model.
    task automatic read_check(input string tag,
                              input logic [15:0] e0, input logic [5:0] a0,
                              input logic [15:0] e1, input logic [5:0] a1);
        read_en_0 = e0; raddr_0 = a0;
        read_en_1 = e1; raddr_1 = a1;
        #1;
        for (int k = 0; k < 16; k++) begin
            chk({tag, "/p0"}, k, int'(a0), rd0[k], e0[k] ? model[k][a0] : 32'h0);
            chk({tag, "/p1"}, k, int'(a1), rd1[k], e1[k] ? model[k][a1] : 32'h0);
        end
    endtask

    // Called just after a negedge; performs one write edge and returns at the
    // following negedge with write_en cleared.
    task automatic do_write(input logic [15:0] we, input logic [5:0] a);
        write_en = we;
        waddr    = a;
        @(posedge clk);
        if (rst_n)
            for (int k = 0; k < 16; k++)
                if (we[k]) model[k][a] = wd[k];
        @(negedge clk);
        write_en = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        write_en  = '0;
        waddr     = '0;
        read_en_0 = '0;
        raddr_0   = '0;
        read_en_1 = '0;
        raddr_1   = '0;
        for (int k = 0; k < 16; k++) wd[k] = '0;
        clear_model();

        // Reset held: a write attempted across an edge must be ignored.
        @(negedge clk);
        randomize_wd();
        do_write(16'hFFFF, 6'd0);
        read_check("reset", 16'hFFFF, 6'd0, 16'hFFFF, 6'd63);
        read_check("reset", 16'hFFFF, 6'd63, 16'hFFFF, 6'd0);
        rst_n = 1'b1;

        // Full-bank sweep with random data.
        for (int a = 0; a < 64; a++) begin
            for (int i = 0; i < 100; i++) begin
                randomize_wd();
                do_write(16'hFFFF, 6'(a));
                read_check("sweep0", 16'hFFFF, 6'(a), 16'h0000, 6'd0);
                read_check("sweep1", 16'h0000, 6'd0, 16'hFFFF, 6'(a));
                read_check("sweepb", 16'hFFFF, 6'(a), 16'hFFFF, 6'(a));
            end
        end

        // Lane masking.
        for (int k = 0; k < 16; k++) wd[k] = 32'hA5A5A5A5;
        do_write(16'hFFFF, 6'd5);
        wd[0] = 32'h12345678;
        do_write(16'h0001, 6'd5);
        read_check("mask", 16'hFFFF, 6'd5, 16'hFFFF, 6'd5);
        chk("mask_l0", 0, 5, rd0[0], 32'h12345678);
        chk("mask_l1", 1, 5, rd0[1], 32'hA5A5A5A5);
        chk("mask_l15", 15, 5, rd1[15], 32'hA5A5A5A5);

        // Read gating on port 0, port 1 on a different address.
        read_check("gate", 16'h00FF, 6'd5, 16'hFFFF, 6'd9);
        chk("gate_l7", 7, 5, rd0[7], 32'hA5A5A5A5);
        chk("gate_l8", 8, 5, rd0[8], 32'h0);

        // Write/read collision at address 9: old before the edge, new after.
        randomize_wd();
        write_en = 16'hFFFF;
        waddr    = 6'd9;
        read_check("coll_pre", 16'hFFFF, 6'd9, 16'hFFFF, 6'd9);
        @(posedge clk);
        for (int k = 0; k < 16; k++) model[k][9] = wd[k];
        read_check("coll_post", 16'hFFFF, 6'd9, 16'hFFFF, 6'd9);
        @(negedge clk);
        write_en = '0;

        // Mid-run reset between edges, held across one edge with a write pending.
        randomize_wd();
        write_en = 16'hFFFF;
        waddr    = 6'd3;
        #2;
        rst_n = 1'b0;
        clear_model();
        read_check("mrst", 16'hFFFF, 6'd3, 16'hFFFF, 6'd63);
        read_check("mrst", 16'hFFFF, 6'd9, 16'hFFFF, 6'd5);
        @(posedge clk);
        read_check("mrst_edge", 16'hFFFF, 6'd3, 16'hFFFF, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        randomize_wd();
        do_write(16'hFFFF, 6'd3);
        read_check("post_rst", 16'hFFFF, 6'd3, 16'hFFFF, 6'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_register_bank_16x64
`default_nettype wire
